// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the F/D/E/M/W pipeline: operand forwarding,
// load-use and branch stall/flush generation, and a memory-wait freeze FSM.
module hazard_ctrl #(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemTimeout,
  output logic [CNT_W-1:0] StallCount
);

  typedef enum logic [1:0] {RUN, MEMWAIT, ERROR} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_wait, w_wait_nxt;
  logic             r_timeout;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_mem_stall;
  logic             w_lw_stall;

  always_comb begin
    ForwardAE = 2'b00;
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))      ForwardAE = 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) ForwardAE = 2'b01;
    ForwardBE = 2'b00;
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))      ForwardBE = 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) ForwardBE = 2'b01;
  end

  assign w_lw_stall = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_wait      <= '0;
      r_timeout   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
      if ((r_state == MEMWAIT) && (w_state_nxt == ERROR)) r_timeout <= 1'b1;
      if (StallF && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait;
    w_mem_stall = 1'b0;
    case (r_state)
      RUN: begin
        if (MemReqM && !MemReadyM) begin
          w_mem_stall = 1'b1;
          w_state_nxt = MEMWAIT;
          w_wait_nxt  = 8'd1;
        end
      end
      MEMWAIT: begin
        if (MemReadyM) begin
          w_state_nxt = RUN;
          w_wait_nxt  = '0;
        end else begin
          w_mem_stall = 1'b1;
          if (r_wait == WAIT_LAST) w_state_nxt = ERROR;
          else                     w_wait_nxt  = r_wait + 8'd1;
        end
      end
      ERROR:   w_mem_stall = 1'b1;
      default: w_state_nxt = RUN;
    endcase
  end

  // A memory freeze holds E as well, so a branch redirect waits until the freeze lifts.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (w_mem_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else begin
      StallF = w_lw_stall;
      StallD = w_lw_stall;
      FlushD = PCSrcE;
      FlushE = w_lw_stall || PCSrcE;
    end
  end

  assign MemTimeout = r_timeout;
  assign StallCount = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed test-plan sequences followed by random
// traffic, checked against a behavioural model of the hazard rules.
module tb_hazard_ctrl;

  localparam int unsigned MAXW = 4;
  localparam int unsigned CW   = 4;
  localparam int          CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic          RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
  logic [1:0]    ResultSrcE;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeout;
  logic [CW-1:0] StallCount;

  hazard_ctrl #(.MAX_WAIT(MAXW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .MemTimeout(MemTimeout), .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int fa, fb;
    int stalls;  // {F,D,E,M}
    int flushes; // {D,E,W}
    int tmo;
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // Model state: how long the current access has been outstanding, whether it died.
  int  m_outstanding = 0;
  bit  m_dead        = 0;
  int  m_cnt         = 0;

  function automatic int fwd(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2;
    if (RegWriteW && RdW != 0 && RdW == rs) return 1;
    return 0;
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clr();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM} = '0;
    ResultSrcE = '0;
  endtask

  // Called once per cycle after inputs settle: push expected outputs, advance the model.
  task automatic check();
    exp_t e;
    bit   lw, mem;
    if (!rst_n) begin
      m_outstanding = 0;
      m_dead        = 0;
      m_cnt         = 0;
    end
    lw  = (ResultSrcE == 2'b01) && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    mem = m_dead || (!MemReadyM && (m_outstanding > 0 || MemReqM));
    e.cyc = cyc;
    e.fa  = fwd(Rs1E);
    e.fb  = fwd(Rs2E);
    if (mem) begin
      e.stalls  = 4'b1111;
      e.flushes = 3'b001;
    end else begin
      e.stalls  = lw ? 4'b1100 : 4'b0000;
      e.flushes = {int'(PCSrcE), int'(lw || PCSrcE), 0} & 3'b110;
      e.flushes = (PCSrcE ? 4 : 0) + ((lw || PCSrcE) ? 2 : 0);
    end
    e.tmo = m_dead ? 1 : 0;
    e.cnt = m_cnt;
    exp_q.push_back(e);
    if (rst_n) begin
      if ((e.stalls & 8) != 0 && m_cnt < CNT_MAX) m_cnt++;
      if (!m_dead) begin
        if (mem) begin
          m_outstanding++;
          if (m_outstanding >= int'(MAXW)) m_dead = 1;
        end else begin
          m_outstanding = 0;
        end
      end
    end
  endtask

  task automatic chk(input string name, input int c, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, c, got, want);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #4;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ForwardAE", e.cyc, int'(ForwardAE), e.fa);
        chk("ForwardBE", e.cyc, int'(ForwardBE), e.fb);
        chk("Stall_FDEM", e.cyc, int'({StallF, StallD, StallE, StallM}), e.stalls);
        chk("Flush_DEW", e.cyc, int'({FlushD, FlushE, FlushW}), e.flushes);
        chk("MemTimeout", e.cyc, int'(MemTimeout), e.tmo);
        chk("StallCount", e.cyc, int'(StallCount), e.cnt);
      end
    end
  end

  initial begin : stim
    rst_n = 1'b0;
    clr();
    sync(); check();
    sync(); rst_n = 1'b1; check();

    // Forwarding priority
    sync(); RdM = 5; RdW = 5; Rs1E = 5; Rs2E = 5; RegWriteM = 1; RegWriteW = 1; check();
    sync(); RegWriteM = 0; check();
    sync(); Rs1E = 0; RdM = 0; RdW = 0; RegWriteM = 1; check();

    // Load-use, then RdE=0 disables it
    sync(); clr(); ResultSrcE = 2'b01; RdE = 7; Rs2D = 7; check();
    sync(); RdE = 0; check();

    // Branch alone, then branch with load-use
    sync(); clr(); PCSrcE = 1; check();
    sync(); ResultSrcE = 2'b01; RdE = 7; Rs1D = 7; check();

    // Three-cycle memory wait with a pending redirect
    sync(); clr(); MemReqM = 1; PCSrcE = 1; check();
    sync(); check();
    sync(); check();
    sync(); MemReadyM = 1; check();
    sync(); clr(); check();

    // Single-cycle access
    sync(); MemReqM = 1; MemReadyM = 1; check();

    // Timeout, late ready ignored, counter saturates
    sync(); clr(); MemReqM = 1; check();
    for (int i = 0; i < 22; i++) begin
      sync(); if (i == 12) MemReadyM = 1; check();
    end
    sync(); rst_n = 1'b0; check();
    sync(); rst_n = 1'b1; clr(); check();

    // Asynchronous reset in the middle of a wait, request still pending afterwards
    sync(); MemReqM = 1; check();
    sync(); check();
    sync(); rst_n = 1'b0; check();
    sync(); rst_n = 1'b1; check();
    sync(); check();
    sync(); clr(); MemReadyM = 1; check();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      sync();
      rst_n      = ($urandom_range(0, 39) != 0);
      Rs1D       = 5'($urandom_range(0, 3));
      Rs2D       = 5'($urandom_range(0, 3));
      Rs1E       = 5'($urandom_range(0, 3));
      Rs2E       = 5'($urandom_range(0, 3));
      RdE        = 5'($urandom_range(0, 3));
      RdM        = 5'($urandom_range(0, 3));
      RdW        = 5'($urandom_range(0, 3));
      RegWriteM  = 1'($urandom_range(0, 1));
      RegWriteW  = 1'($urandom_range(0, 1));
      ResultSrcE = 2'($urandom_range(0, 3));
      PCSrcE     = ($urandom_range(0, 3) == 0);
      MemReqM    = ($urandom_range(0, 9) < 3);
      MemReadyM  = ($urandom_range(0, 9) < 6);
      check();
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #6;
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Central hazard and sequencing controller for the five-stage pipeline (F/D/E/M/W). It performs three jobs:
- Generates the E-stage operand forwarding selects.
- Detects load-use hazards and branch-taken redirects, and produces the per-stage stall/flush controls consumed by the pipeline registers (including the M->W control register).
- Runs a small FSM that freezes the pipeline while a multi-cycle data-memory access in M is outstanding, with timeout detection and a stall-cycle performance counter.

Parameters:
- MAX_WAIT, 16: cycles a data-memory access may wait for MemReadyM before timeout (legal range 2..255).
- CNT_W, 16: width of the stall-cycle performance counter.

Ports:
- clk  in  1  pipeline clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- Rs1D  in  5  source register 1 of the instruction in D.
- Rs2D  in  5  source register 2 of the instruction in D.
- Rs1E  in  5  source register 1 of the instruction in E.
- Rs2E  in  5  source register 2 of the instruction in E.
- RdE  in  5  destination register in E.
- RdM  in  5  destination register in M.
- RdW  in  5  destination register in W.
- RegWriteM  in  1  M-stage instruction writes the register file.
- RegWriteW  in  1  W-stage instruction writes the register file.
- ResultSrcE  in  2  E-stage result source; 2'b01 = load.
- PCSrcE  in  1  branch/jump taken, resolved in E.
- MemReqM  in  1  load/store present in M.
- MemReadyM  in  1  data memory completes the M-stage access this cycle.
- ForwardAE  out  2  SrcA select: 00 register file, 01 W result, 10 M ALU result.
- ForwardBE  out  2  SrcB select, same encoding.
- StallF  out  1  hold PC.
- StallD  out  1  hold F/D register.
- StallE  out  1  hold D/E register.
- StallM  out  1  hold E/M register.
- FlushD  out  1  clear F/D register.
- FlushE  out  1  clear D/E register.
- FlushW  out  1  clear M/W register (insert bubble into W).
- MemTimeout  out  1  sticky: memory access exceeded MAX_WAIT.
- StallCount  out  CNT_W  saturating count of cycles with StallF=1.

Behaviour:

Forwarding (combinational):
- ForwardAE = 10 if RegWriteM && RdM!=0 && RdM==Rs1E.
- Else ForwardAE = 01 if RegWriteW && RdW!=0 && RdW==Rs1E.
- Else ForwardAE = 00.
- M has priority over W. ForwardBE is identical using Rs2E.
- Forwarding is computed in every FSM state.

Load-use detection:
- lwStall = (ResultSrcE==2'b01) && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).

FSM states: RUN, MEMWAIT, ERROR. Reset state is RUN.
- RUN:
  - memStall = MemReqM && !MemReadyM.
  - If memStall: go to MEMWAIT, waitCnt <= 1.
- MEMWAIT:
  - memStall = !MemReadyM.
  - If MemReadyM: memStall=0 this cycle, go to RUN, waitCnt <= 0.
  - Else if waitCnt==MAX_WAIT-1: go to ERROR.
  - Else waitCnt <= waitCnt+1.
- ERROR:
  - memStall forced 1. Terminal until rst_n asserts.
  - MemTimeout=1 (registered, set on the MEMWAIT->ERROR edge, so first high in the ERROR cycle).
- A single-cycle access (MemReadyM=1 in the same cycle as MemReqM) produces no stall and no state change.

Stall/flush equations (combinational):
- memStall=1: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=0, FlushE=0. This overrides load-use and branch handling; E is frozen, so the redirect is applied once memStall drops.
- memStall=0:
  - StallF = StallD = lwStall.
  - StallE = StallM = 0.
  - FlushD = PCSrcE.
  - FlushE = lwStall || PCSrcE.
  - FlushW = 0.

StallCount:
- Increments each cycle StallF=1.
- Saturates at all-ones, with no wrap.

Reset (rst_n low, asynchronous):
- state=RUN, waitCnt=0, MemTimeout=0, StallCount=0.
- Outputs then reflect RUN-state combinational equations. With all inputs 0, every stall/flush/forward output is 0.
- Reset during MEMWAIT or ERROR returns to RUN immediately. A still-pending MemReqM && !MemReadyM re-enters MEMWAIT on the first edge after release.

Test Plan:
- Forwarding priority: RdM=RdW=Rs1E=5, RegWriteM=RegWriteW=1 -> ForwardAE=10. RegWriteM=0 -> 01. Rs1E=0 with RdM=RdW=0 -> 00.
- Load-use: ResultSrcE=01, RdE=7, Rs2D=7 -> StallF=StallD=1, FlushE=1, StallE=0. RdE=0 -> all 0. StallCount increments by 1.
- Branch: PCSrcE=1, no other hazard -> FlushD=1, FlushE=1, no stalls. With lwStall also 1 -> StallF=StallD=1, FlushD=FlushE=1.
- Memory wait: MemReqM=1, MemReadyM=0 for 3 cycles then 1 -> StallF..StallM and FlushW high exactly 3 cycles, low in the ready cycle, state back to RUN, StallCount=3. PCSrcE=1 during the wait -> FlushD/FlushE stay 0 until the ready cycle.
- Timeout: MAX_WAIT=4, MemReadyM held 0 -> ERROR entered after 4 stall cycles, MemTimeout=1 and stalls stay 1 indefinitely. MemReadyM=1 later has no effect. rst_n pulse low -> MemTimeout=0, StallCount=0.
- Saturation/reset: CNT_W=4, stall 20 cycles -> StallCount=15 held. Assert rst_n mid-MEMWAIT -> outputs drop the same cycle, with no clock edge needed.
